// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector with overlap/non-overlap modes,
// a registered one-cycle match pulse and a saturating match counter.
module seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('b1011),
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1,
  localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [MAX_LEN-1:0] pattern_r;
  logic [LEN_W-1:0]   len_r;
  logic               overlap_r;
  logic [MAX_LEN-1:0] hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic [CNT_W-1:0]   count_r;
  logic               dout_p1;

  logic               vld_p0;
  logic               match_p0;
  logic [MAX_LEN-1:0] hist_p0;
  logic [LEN_W-1:0]   fill_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : l;
  endfunction

  // Ones in the low l bits: selects the part of the history that is compared.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      m[i] = (i < int'(l));
    end
    return m;
  endfunction

  // Stage p0: shift in the candidate bit and compare against the pattern
  always_comb begin
    vld_p0   = (state_q == ARMED) && din_valid && !cfg_load;
    hist_p0  = {hist_r[MAX_LEN-2:0], din};
    fill_p0  = (fill_r == LEN_W'(MAX_LEN)) ? fill_r : fill_r + 1'b1;
    match_p0 = vld_p0 && (fill_p0 >= len_r) &&
               (((hist_p0 ^ pattern_r) & len_mask(len_r)) == '0);
  end

  always_comb begin
    state_d = state_q;
    if (cfg_load) begin
      state_d = (cfg_len == '0) ? IDLE : ARMED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (DEF_LEN != 0) ? ARMED : IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage p1: registered history, match pulse and counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_r <= DEF_PATTERN;
      len_r     <= LEN_W'(DEF_LEN);
      overlap_r <= DEF_OVERLAP;
      hist_r    <= '0;
      fill_r    <= '0;
      dout_p1   <= 1'b0;
    end else if (cfg_load) begin
      pattern_r <= cfg_pattern;
      len_r     <= clamp_len(cfg_len);
      overlap_r <= cfg_overlap;
      hist_r    <= '0;
      fill_r    <= '0;
      dout_p1   <= 1'b0;
    end else if (vld_p0) begin
      hist_r  <= hist_p0;
      // Non-overlapping mode restarts from an empty history after each hit.
      fill_r  <= (match_p0 && !overlap_r) ? '0 : fill_p0;
      dout_p1 <= match_p0;
    end else begin
      dout_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (cnt_clr) begin
      count_r <= match_p0 ? CNT_W'(1) : '0;
    end else if (match_p0) begin
      count_r <= sat_inc(count_r);
    end
  end

  assign dout        = dout_p1;
  assign match_count = count_r;
  assign armed       = (state_q == ARMED);

endmodule
